approx_product_accumulator: RTL and testbench
=============================================

APPROX_PRODUCT_ACCUMULATOR -- requirements
Module: approx_product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 16, width of incoming approximate 8x8 product.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator and result width.
REQ-003 SHALL have parameter CNT_W, default 9, beat-counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port clr  input  1  synchronous discard of the partial accumulation.
REQ-007 SHALL have port in_valid  input  1  product beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port in_data  input  PROD_W  unsigned product z from the multiplier stage.
REQ-010 SHALL have port in_last  input  1  final beat of the current dot-product vector.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  ACC_W  saturated unsigned dot-product sum.
REQ-014 SHALL have port out_count  output  CNT_W  number of beats in the vector, saturating.
REQ-015 SHALL have port out_sat  output  1  sum saturated at some point in the vector.

Function
REQ-016 SHALL implement a two-state FSM: ACC (accepting beats) and HOLD (result presented).
REQ-017 SHALL drive in_ready = 1 in ACC and 0 in HOLD, decoded from the registered state only.
REQ-018 SHALL, on an ACC-state handshake (in_valid & in_ready) with in_last=0, set acc <= sat(acc + zero-extended in_data), cnt <= satinc(cnt), and sat_flag <= sat_flag | overflow.
REQ-019 SHALL, on an ACC-state handshake with in_last=1, load out_data, out_count and out_sat with the values REQ-018 would produce, set out_valid=1, clear acc, cnt and sat_flag, and enter HOLD; the result is visible the cycle after the last beat.
REQ-020 SHALL saturate the sum at 2^ACC_W-1 and the beat count at 2^CNT_W-1; neither wraps.
REQ-021 SHALL hold out_data, out_count, out_sat and out_valid stable in HOLD until out_valid & out_ready; on that edge it SHALL clear out_valid and return to ACC, with no beat accepted in that same cycle.
REQ-022 SHALL, on clr=1 in ACC, zero acc, cnt and sat_flag and ignore any beat presented that cycle; clr SHALL take priority over in_valid.
REQ-023 SHALL ignore clr in HOLD; the pending result is never discarded.
REQ-024 SHALL treat a beat with in_data=0 as a counted beat.
REQ-025 SHALL accept back-to-back beats at one per cycle in ACC; minimum vector-to-vector gap is the HOLD cycle(s).

Reset
REQ-026 SHALL, while rst_n=0, force state=ACC, acc=0, cnt=0, sat_flag=0, out_valid=0, out_data=0, out_count=0, out_sat=0.
REQ-027 SHALL abandon any partial vector or unaccepted result on reset assertion, with no residual output after release.

Structure
REQ-028 SHALL take PROD_W, ACC_W and CNT_W defaults and the ACC/HOLD state enum from the shared package approx_mult_pkg.
REQ-029 SHALL place the saturating add-with-overflow-flag in one combinational sub-module, sat_add, instantiated once; the counter saturation is inline.
REQ-030 SHALL require ACC_W > PROD_W, checked by elaboration-time assertion.

Verification
REQ-031 SHALL cover beats 100, 200, 300 (last on 300) -> out_data=600, out_count=3, out_sat=0, out_valid one cycle after the last beat.
REQ-032 SHALL cover a single beat 0xFFFF with in_last=1 -> out_data=0x00FFFF, out_count=1, in_ready=0 until out_ready.
REQ-033 SHALL cover 300 beats of 0xFFFF -> out_data=0xFFFFFF, out_sat=1, out_count=300.
REQ-034 SHALL cover out_ready held low 5 cycles with in_valid=1 -> result stable, no beats accepted, then next vector sums from 0.
REQ-035 SHALL cover clr after beats 7 and 9, then beats 4 and 5 (last) -> out_data=9, out_count=2.
REQ-036 SHALL cover rst_n asserted mid-vector and in HOLD -> all outputs 0 immediately, and a fresh vector of 1 and 2 yields out_data=3.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared widths and state encoding for the approximate-multiplier datapath.
package approx_mult_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 9;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: a + zero-extended b, clamped at all-ones, with overflow flag.
module sat_add #(
  parameter int A_W = 24,
  parameter int B_W = 16
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           ovf
);

  logic [A_W:0] sum_ext;

  always_comb begin
    sum_ext = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
    ovf     = sum_ext[A_W];
    sum     = ovf ? {A_W{1'b1}} : sum_ext[A_W-1:0];
  end

endmodule

// File: rtl/approx_product_accumulator.sv
// Accumulates a vector of approximate products into a saturating sum and presents
// the sum, beat count and saturation flag as one valid/ready result.
module approx_product_accumulator
  import approx_mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  if (ACC_W <= PROD_W) begin : g_width_check
    $error("approx_product_accumulator: ACC_W must be greater than PROD_W");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on registered state; out_valid/out_data hold until taken.
  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic [CNT_W-1:0] cnt_inc;

  sat_add #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (sum),
    .ovf (ovf)
  );

  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_ACC: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          if (in_last) begin
            out_data_d  = sum;
            out_count_d = cnt_inc;
            out_sat_d   = sat_q | ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
            sat_d = sat_q | ovf;
          end
        end
      end
      ST_HOLD: begin
        // clr is deliberately ignored here so a finished result is never lost.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Directed bench for approx_product_accumulator with a result scoreboard.
module tb_approx_product_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 9;
  localparam int RES_W  = ACC_W + CNT_W + 1;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  int total = 0;
  int bad   = 0;

  logic [RES_W-1:0] exp_q[$];
  logic [ACC_W-1:0] m_acc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_sat;

  approx_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  task automatic model_beat(input logic [PROD_W-1:0] d, input logic last);
    logic [ACC_W:0] s;
    s = {1'b0, m_acc} + (ACC_W + 1)'(d);
    if (s > (ACC_W + 1)'(2 ** ACC_W - 1)) begin
      m_acc = {ACC_W{1'b1}};
      m_sat = 1'b1;
    end else begin
      m_acc = s[ACC_W-1:0];
    end
    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (last) begin
      exp_q.push_back({m_acc, m_cnt, m_sat});
      model_clear();
    end
  endtask

  // driver: present one beat, wait for acceptance
  task automatic send_beat(input logic [PROD_W-1:0] d, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("beat_accept");
    @(posedge clk);
    model_beat(d, last);
    if (last) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("valid_next_cycle", 32'(out_valid), 32'd1);
      check("ready_low_in_hold", 32'(in_ready), 32'd0);
    end
  endtask

  // scoreboard: pop expected result, compare, stall, then accept
  task automatic collect(input int hold_n, input logic drive_valid);
    int n;
    logic [RES_W-1:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      fail("result_wait");
    end else if (exp_q.size() == 0) begin
      fail("unexpected_result");
    end else begin
      e = exp_q.pop_front();
      check("out_data", 32'(out_data), 32'(e[RES_W-1 -: ACC_W]));
      check("out_count", 32'(out_count), 32'(e[CNT_W:1]));
      check("out_sat", 32'(out_sat), 32'(e[0]));
      for (int i = 0; i < hold_n; i++) begin
        if (drive_valid) begin
          in_valid = 1'b1;
          in_data  = 16'h1234;
          in_last  = 1'b0;
        end
        @(negedge clk);
        check("hold_data_stable", 32'(out_data), 32'(e[RES_W-1 -: ACC_W]));
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_no_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("valid_cleared", 32'(out_valid), 32'd0);
      check("ready_after_take", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    check({tag, "_sat"}, 32'(out_sat), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int len;
    logic [PROD_W-1:0] d;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // 100 + 200 + 300
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    send_beat(16'd300, 1'b1);
    collect(0, 1'b0);

    // single full-scale beat, stalled downstream
    send_beat(16'hFFFF, 1'b1);
    collect(3, 1'b0);

    // 300 full-scale beats saturate the sum
    for (int i = 0; i < 300; i++) send_beat(16'hFFFF, i == 299);
    collect(1, 1'b0);

    // out_ready low 5 cycles with in_valid high, then fresh vector
    send_beat(16'd40, 1'b0);
    send_beat(16'd2, 1'b1);
    collect(5, 1'b1);
    send_beat(16'd8, 1'b1);
    collect(0, 1'b0);

    // clr discards partial sum and wins over a presented beat
    send_beat(16'd7, 1'b0);
    send_beat(16'd9, 1'b0);
    @(negedge clk);
    clr     = 1'b1;
    in_data = 16'd50;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    send_beat(16'd4, 1'b0);
    send_beat(16'd5, 1'b1);
    collect(0, 1'b0);

    // clr in HOLD does not drop the result
    send_beat(16'd77, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    collect(1, 1'b0);

    // zero-valued beats still count
    send_beat(16'd0, 1'b0);
    send_beat(16'd0, 1'b0);
    send_beat(16'd5, 1'b1);
    collect(0, 1'b0);

    // random vector
    len = $urandom_range(3, 8);
    for (int i = 0; i < len; i++) begin
      d = PROD_W'($urandom_range(0, 65535));
      send_beat(d, i == len - 1);
    end
    collect(2, 1'b0);

    // reset mid-vector
    send_beat(16'd11, 1'b0);
    send_beat(16'd22, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b1);
    collect(0, 1'b0);

    // reset while holding a result
    send_beat(16'd5, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_hold");
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("post_rst");
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b1);
    collect(0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
